// File: rtl/supercar_pkg.sv
// Shared constants and types for the Supercar trail display stage.
// Scan width, brightness depth and the two-state sweep tracker live here.
package supercar_pkg;

    localparam int SCAN_N  = 19;
    localparam int LEVEL_W = 3;
    localparam int IDX_W   = $clog2(SCAN_N);

    typedef logic [LEVEL_W-1:0] level_t;
    typedef logic [IDX_W-1:0]   idx_t;

    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } state_t;

endpackage

// File: rtl/msb_index.sv
// Combinational priority encoder: index of the highest set bit of pos.
// A multi-hot word resolves to its MSB; valid flags a nonzero word.
module msb_index #(
    parameter int N  = 19,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  pos,
    output logic [IW-1:0] idx,
    output logic          valid
);

    // Ascending scan so the last hit, the highest bit, wins.
    always_comb begin
        idx   = '0;
        valid = |pos;
        for (int i = 0; i < N; i++) begin
            if (pos[i]) begin
                idx = IW'(i);
            end
        end
    end

endmodule

// File: rtl/supercar_trail.sv
// Display stage behind the Supercar scan register: bounces the one-way scan
// into a back-and-forth sweep and drives a PWM-faded trail on the LEDs.
module supercar_trail #(
    parameter int N       = supercar_pkg::SCAN_N,
    parameter int LEVEL_W = supercar_pkg::LEVEL_W
) (
    input  logic         CLK,
    input  logic         reset,
    input  logic         step,
    input  logic [N-1:0] pos,
    input  logic         mirror_en,
    output logic [N-1:0] led,
    output logic         dir,
    output logic         wrap,
    output logic         bad_pos
);

    import supercar_pkg::*;

    localparam int                 IW   = $clog2(N);
    localparam logic [IW-1:0]      LAST = IW'(N - 1);
    localparam logic [LEVEL_W-1:0] MAXL = '1;

    logic [IW-1:0]      idx;
    logic               pos_valid;
    logic [IW-1:0]      prev_idx;
    logic [IW-1:0]      prev_next;
    logic [IW-1:0]      disp;
    state_t             state;
    state_t             state_next;
    logic               dir_next;
    logic               wrap_next;
    logic               bad_next;
    logic [LEVEL_W-1:0] level [N];
    logic [LEVEL_W-1:0] pwm_cnt;

    msb_index #(
        .N  (N),
        .IW (IW)
    ) u_msb_index (
        .pos   (pos),
        .idx   (idx),
        .valid (pos_valid)
    );

    always_ff @(posedge CLK) begin
        if (reset) begin
            state    <= ST_IDLE;
            prev_idx <= '0;
            dir      <= 1'b0;
            wrap     <= 1'b0;
            bad_pos  <= 1'b0;
        end else begin
            state    <= state_next;
            prev_idx <= prev_next;
            dir      <= dir_next;
            wrap     <= wrap_next;
            bad_pos  <= bad_next;
        end
    end

    // The scan register only shifts one way, so an index that jumps upward
    // means it reloaded; that is where the displayed sweep turns around.
    always_comb begin
        state_next = state;
        prev_next  = prev_idx;
        dir_next   = dir;
        wrap_next  = 1'b0;
        bad_next   = 1'b0;
        if (step) begin
            if (!pos_valid) begin
                bad_next = 1'b1;
            end else begin
                state_next = ST_RUN;
                prev_next  = idx;
                if (state == ST_RUN && idx > prev_idx) begin
                    wrap_next = 1'b1;
                    dir_next  = ~dir;
                end
            end
        end
        disp = (mirror_en && dir_next) ? LAST - idx : idx;
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            for (int i = 0; i < N; i++) begin
                level[i] <= '0;
            end
        end else if (step) begin
            for (int i = 0; i < N; i++) begin
                if (pos_valid && disp == IW'(i)) begin
                    level[i] <= MAXL;
                end else if (level[i] != '0) begin
                    level[i] <= level[i] - 1'b1;
                end
            end
        end
    end

    // Counter spans MAXL values so full brightness stays solidly on.
    always_ff @(posedge CLK) begin
        if (reset) begin
            pwm_cnt <= '0;
            led     <= '0;
        end else begin
            pwm_cnt <= (pwm_cnt == MAXL - 1'b1) ? '0 : pwm_cnt + 1'b1;
            for (int i = 0; i < N; i++) begin
                led[i] <= (level[i] > pwm_cnt);
            end
        end
    end

endmodule

// File: tb/tb_supercar_trail.sv
// Directed bench for supercar_trail: sweep, bounce, trail decay, PWM duty,
// invalid positions and resets, each checked against hand-derived values.
module tb_supercar_trail;
    import supercar_pkg::*;

    logic        CLK = 1'b0;
    logic        reset = 1'b1;
    logic        step = 1'b0;
    logic [18:0] pos = '0;
    logic        mirror_en = 1'b1;
    logic [18:0] led;
    logic        dir;
    logic        wrap;
    logic        bad_pos;

    int n_cmp = 0;
    int n_bad = 0;

    supercar_trail dut (
        .CLK       (CLK),
        .reset     (reset),
        .step      (step),
        .pos       (pos),
        .mirror_en (mirror_en),
        .led       (led),
        .dir       (dir),
        .wrap      (wrap),
        .bad_pos   (bad_pos)
    );

    always #5 CLK = ~CLK;

    // One isolated step; returns at the negedge after the sampling edge.
    task applyStimulus(input logic [18:0] p);
        @(negedge CLK);
        step = 1'b1;
        pos  = p;
        @(negedge CLK);
        step = 1'b0;
        pos  = '0;
    endtask

    task test_reset;
        reset = 1'b1;
        repeat (3) @(negedge CLK);
        reset = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge CLK);
            n_cmp++;
            if (led !== 19'd0 || dir !== 1'b0 || wrap !== 1'b0 || bad_pos !== 1'b0) begin
                n_bad++;
                $display("[TB] FAIL reset_idle cycle %0d: led=%h dir=%b wrap=%b bad=%b want all 0",
                         c, led, dir, wrap, bad_pos);
            end
        end
        n_cmp++;
        if (dut.state !== ST_IDLE) begin
            n_bad++;
            $display("[TB] FAIL reset_state: got %0d want IDLE", dut.state);
        end
    endtask

    task test_first_steps;
        applyStimulus(19'h40000);
        n_cmp++;
        if (dut.level[18] !== 3'd7 || wrap !== 1'b0 || dut.state !== ST_RUN) begin
            n_bad++;
            $display("[TB] FAIL first_step: level18=%0d wrap=%b state=%0d want 7 0 RUN",
                     dut.level[18], wrap, dut.state);
        end
        applyStimulus(19'h20000);
        n_cmp++;
        if (dut.level[17] !== 3'd7 || dut.level[18] !== 3'd6 || wrap !== 1'b0) begin
            n_bad++;
            $display("[TB] FAIL second_step: level17=%0d level18=%0d wrap=%b want 7 6 0",
                     dut.level[17], dut.level[18], wrap);
        end
        @(negedge CLK);
        for (int c = 0; c < 14; c++) begin
            @(negedge CLK);
            n_cmp++;
            if (led[17] !== 1'b1) begin
                n_bad++;
                $display("[TB] FAIL led17_on cycle %0d: got %b want 1", c, led[17]);
            end
        end
    endtask

    task test_wrap;
        for (int k = 16; k >= 1; k--) begin
            applyStimulus(19'd1 << k);
            n_cmp++;
            if (wrap !== 1'b0 || dir !== 1'b0 || dut.level[k] !== 3'd7) begin
                n_bad++;
                $display("[TB] FAIL sweep_fwd k=%0d: wrap=%b dir=%b level=%0d want 0 0 7",
                         k, wrap, dir, dut.level[k]);
            end
        end
        applyStimulus(19'h40000);
        n_cmp++;
        if (wrap !== 1'b1 || dir !== 1'b1 || dut.level[0] !== 3'd7 || dut.prev_idx !== 5'd18) begin
            n_bad++;
            $display("[TB] FAIL wrap1: wrap=%b dir=%b level0=%0d prev=%0d want 1 1 7 18",
                     wrap, dir, dut.level[0], dut.prev_idx);
        end
        @(negedge CLK);
        n_cmp++;
        if (wrap !== 1'b0) begin
            n_bad++;
            $display("[TB] FAIL wrap1_width: got %b want 0", wrap);
        end
        for (int k = 17; k >= 1; k--) begin
            applyStimulus(19'd1 << k);
            n_cmp++;
            if (wrap !== 1'b0 || dir !== 1'b1 || dut.level[18-k] !== 3'd7) begin
                n_bad++;
                $display("[TB] FAIL sweep_mirror k=%0d: wrap=%b dir=%b level=%0d want 0 1 7",
                         k, wrap, dir, dut.level[18-k]);
            end
        end
        applyStimulus(19'h40000);
        n_cmp++;
        if (wrap !== 1'b1 || dir !== 1'b0 || dut.level[18] !== 3'd7) begin
            n_bad++;
            $display("[TB] FAIL wrap2: wrap=%b dir=%b level18=%0d want 1 0 7",
                     wrap, dir, dut.level[18]);
        end
    endtask

    task test_pwm_duty;
        int on15;
        int on12;
        int on11;
        for (int k = 15; k >= 11; k--) begin
            applyStimulus(19'd1 << k);
        end
        n_cmp++;
        if (dut.level[15] !== 3'd3) begin
            n_bad++;
            $display("[TB] FAIL pwm_level15: got %0d want 3", dut.level[15]);
        end
        @(negedge CLK);
        for (int w = 0; w < 3; w++) begin
            on15 = 0;
            on12 = 0;
            on11 = 0;
            repeat (7) begin
                @(negedge CLK);
                on15 += int'(led[15]);
                on12 += int'(led[12]);
                on11 += int'(led[11]);
            end
            n_cmp++;
            if (on15 != 3 || on12 != 6 || on11 != 7) begin
                n_bad++;
                $display("[TB] FAIL pwm_window %0d: on15=%0d on12=%0d on11=%0d want 3 6 7",
                         w, on15, on12, on11);
            end
        end
    endtask

    task test_bad_pos;
        applyStimulus(19'd0);
        n_cmp++;
        if (bad_pos !== 1'b1 || wrap !== 1'b0 || dir !== 1'b0 ||
            dut.prev_idx !== 5'd11 || dut.state !== ST_RUN) begin
            n_bad++;
            $display("[TB] FAIL bad_pulse: bad=%b wrap=%b dir=%b prev=%0d state=%0d want 1 0 0 11 RUN",
                     bad_pos, wrap, dir, dut.prev_idx, dut.state);
        end
        n_cmp++;
        if (dut.level[15] !== 3'd2 || dut.level[14] !== 3'd3 ||
            dut.level[11] !== 3'd6 || dut.level[18] !== 3'd1) begin
            n_bad++;
            $display("[TB] FAIL bad_decay: l15=%0d l14=%0d l11=%0d l18=%0d want 2 3 6 1",
                     dut.level[15], dut.level[14], dut.level[11], dut.level[18]);
        end
        @(negedge CLK);
        n_cmp++;
        if (bad_pos !== 1'b0) begin
            n_bad++;
            $display("[TB] FAIL bad_width: got %b want 0", bad_pos);
        end
    endtask

    task test_reset_mid;
        int nz;
        @(negedge CLK);
        reset = 1'b1;
        step  = 1'b1;
        pos   = 19'h00100;
        @(negedge CLK);
        reset = 1'b0;
        step  = 1'b0;
        pos   = '0;
        nz = 0;
        for (int i = 0; i < 19; i++) begin
            if (dut.level[i] !== 3'd0) nz++;
        end
        n_cmp++;
        if (nz != 0 || led !== 19'd0 || dut.state !== ST_IDLE || dir !== 1'b0 || dut.prev_idx !== 5'd0) begin
            n_bad++;
            $display("[TB] FAIL reset_mid: nonzero_levels=%0d led=%h state=%0d dir=%b prev=%0d want 0 0 IDLE 0 0",
                     nz, led, dut.state, dir, dut.prev_idx);
        end
        applyStimulus(19'h00100);
        n_cmp++;
        if (wrap !== 1'b0 || dut.level[8] !== 3'd7 || dut.state !== ST_RUN) begin
            n_bad++;
            $display("[TB] FAIL after_reset_step: wrap=%b level8=%0d state=%0d want 0 7 RUN",
                     wrap, dut.level[8], dut.state);
        end
    endtask

    task test_back_to_back;
        @(negedge CLK);
        step = 1'b1;
        pos  = 19'h00080;
        @(negedge CLK);
        pos  = 19'h00040;
        @(negedge CLK);
        pos  = 19'h00020;
        @(negedge CLK);
        step = 1'b0;
        pos  = '0;
        n_cmp++;
        if (dut.level[8] !== 3'd4 || dut.level[7] !== 3'd5 || dut.level[6] !== 3'd6 ||
            dut.level[5] !== 3'd7 || wrap !== 1'b0) begin
            n_bad++;
            $display("[TB] FAIL b2b_levels: l8=%0d l7=%0d l6=%0d l5=%0d wrap=%b want 4 5 6 7 0",
                     dut.level[8], dut.level[7], dut.level[6], dut.level[5], wrap);
        end
        step = 1'b1;
        pos  = 19'h40000;
        @(negedge CLK);
        n_cmp++;
        if (wrap !== 1'b1 || dir !== 1'b1) begin
            n_bad++;
            $display("[TB] FAIL b2b_wrap: wrap=%b dir=%b want 1 1", wrap, dir);
        end
        pos = 19'h20000;
        @(negedge CLK);
        step = 1'b0;
        pos  = '0;
        n_cmp++;
        if (wrap !== 1'b0 || dir !== 1'b1 || dut.level[1] !== 3'd7 || dut.level[0] !== 3'd6) begin
            n_bad++;
            $display("[TB] FAIL b2b_after_wrap: wrap=%b dir=%b l1=%0d l0=%0d want 0 1 7 6",
                     wrap, dir, dut.level[1], dut.level[0]);
        end
    endtask

    initial begin
        test_reset;
        test_first_steps;
        test_wrap;
        test_pwm_duty;
        test_bad_pos;
        test_reset_mid;
        test_back_to_back;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
